// File: rtl/hero_collision_scan_if.sv
// Scan request, hero positions, wall ROM port and published collision flags.
// The master side issues scans and serves ROM reads; the slave side is the scanner.
interface hero_collision_scan_if #(
  parameter int unsigned ADDR_W = 5
);
  logic              start;
  logic [23:0]       x_pos;
  logic [23:0]       y_pos;
  logic [ADDR_W-1:0] wall_addr;
  logic [47:0]       wall_data;
  logic [7:0]        collision;
  logic              busy;
  logic              done;

  modport master (
    output start, x_pos, y_pos, wall_data,
    input  wall_addr, collision, busy, done
  );

  modport slave (
    input  start, x_pos, y_pos, wall_data,
    output wall_addr, collision, busy, done
  );
endinterface

// File: rtl/hero_collision_scan.sv
// Walks the wall table against four shifted probes per hero, adds a hero-vs-hero
// check, and publishes the eight blocked flags atomically with a done pulse.
module hero_collision_scan #(
  parameter int unsigned N_WALLS = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned SIDE    = 60
) (
  input logic             clk,
  input logic             rst,
  hero_collision_scan_if.slave bus
);

  typedef logic signed [13:0] s14_t;
  typedef enum logic [1:0] {StIdle, StScan, StDrain, StHero} state_t;

  localparam s14_t Side14 = s14_t'(SIDE);
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(N_WALLS - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] index_q;
  logic [23:0]       x_snap_q;
  logic [23:0]       y_snap_q;
  logic [7:0]        acc_q;
  logic [7:0]        collision_q;
  logic              busy_q;
  logic              done_q;

  function automatic s14_t ext(input logic [11:0] v);
    return s14_t'({2'b00, v});
  endfunction

  // Half-open interval test on both axes; zero-size rectangles never hit.
  function automatic logic overlap(input s14_t px, input s14_t py, input s14_t rx,
                                   input s14_t ry, input s14_t rw, input s14_t rh);
    return (rw != '0) && (rh != '0) &&
           (px < rx + rw) && (rx < px + Side14) &&
           (py < ry + rh) && (ry < py + Side14);
  endfunction

  // Bit order: -x, +x, +y, -y.
  function automatic logic [3:0] probe_hits(input s14_t hx, input s14_t hy, input s14_t rx,
                                            input s14_t ry, input s14_t rw, input s14_t rh);
    logic [3:0] h;
    h[0] = overlap(hx - s14_t'(1), hy, rx, ry, rw, rh);
    h[1] = overlap(hx + s14_t'(1), hy, rx, ry, rw, rh);
    h[2] = overlap(hx, hy + s14_t'(1), rx, ry, rw, rh);
    h[3] = overlap(hx, hy - s14_t'(1), rx, ry, rw, rh);
    return h;
  endfunction

  s14_t h1x, h1y, h2x, h2y, wx, wy, ww, wh;
  logic [7:0] wall_hit;
  logic [7:0] hero_hit;

  assign h1x = ext(x_snap_q[11:0]);
  assign h1y = ext(y_snap_q[11:0]);
  assign h2x = ext(x_snap_q[23:12]);
  assign h2y = ext(y_snap_q[23:12]);
  assign wx  = ext(bus.wall_data[47:36]);
  assign wy  = ext(bus.wall_data[35:24]);
  assign ww  = ext(bus.wall_data[23:12]);
  assign wh  = ext(bus.wall_data[11:0]);

  assign wall_hit = {probe_hits(h2x, h2y, wx, wy, ww, wh),
                     probe_hits(h1x, h1y, wx, wy, ww, wh)};
  assign hero_hit = {probe_hits(h2x, h2y, h1x, h1y, Side14, Side14),
                     probe_hits(h1x, h1y, h2x, h2y, Side14, Side14)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      index_q     <= '0;
      x_snap_q    <= '0;
      y_snap_q    <= '0;
      acc_q       <= '0;
      collision_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            x_snap_q <= bus.x_pos;
            y_snap_q <= bus.y_pos;
            acc_q    <= '0;
            index_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= StScan;
          end
        end
        StScan: begin
          // Data on the bus belongs to the address issued last cycle.
          if (index_q != '0) acc_q <= acc_q | wall_hit;
          if (index_q == LastIdx) state_q <= StDrain;
          else                    index_q <= index_q + ADDR_W'(1);
        end
        StDrain: begin
          acc_q   <= acc_q | wall_hit;
          index_q <= '0;
          state_q <= StHero;
        end
        StHero: begin
          collision_q <= acc_q | hero_hit;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.wall_addr = index_q;
  assign bus.collision = collision_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_hero_collision_scan.sv
// Directed vector table, randomized scans against an integer reference model, and
// hand-written sequences for snapshot, back-to-back and reset corner cases.
module tb_hero_collision_scan;
  localparam int unsigned NW   = 32;
  localparam int unsigned AW   = 5;
  localparam int          SIDE = 60;
  localparam int          LAT  = NW + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hero_collision_scan_if #(.ADDR_W(AW)) bus ();

  hero_collision_scan #(.N_WALLS(NW), .ADDR_W(AW), .SIDE(SIDE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [47:0] rom [NW];
  always @(posedge clk) bus.wall_data <= rom[bus.wall_addr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] wall(input int x, input int y, input int w, input int h);
    return {12'(x), 12'(y), 12'(w), 12'(h)};
  endfunction

  function automatic bit ovl(input int ax, input int ay, input int bx, input int by,
                             input int bw, input int bh);
    return bw > 0 && bh > 0 && ax < bx + bw && bx < ax + SIDE && ay < by + bh && by < ay + SIDE;
  endfunction

  // Reference: every hero, every probe direction, against every wall and the other hero.
  function automatic logic [7:0] model(input int x1, input int y1, input int x2, input int y2);
    int hx[2];
    int hy[2];
    int dx[4];
    int dy[4];
    int px, py;
    logic [7:0] r;
    hx = '{x1, x2};
    hy = '{y1, y2};
    dx = '{-1, 1, 0, 0};
    dy = '{0, 0, 1, -1};
    r = '0;
    for (int h = 0; h < 2; h++) begin
      for (int d = 0; d < 4; d++) begin
        px = hx[h] + dx[d];
        py = hy[h] + dy[d];
        for (int i = 0; i < int'(NW); i++) begin
          if (ovl(px, py, int'(rom[i][47:36]), int'(rom[i][35:24]),
                  int'(rom[i][23:12]), int'(rom[i][11:0])))
            r[h*4+d] = 1'b1;
        end
        if (ovl(px, py, hx[1-h], hy[1-h], SIDE, SIDE)) r[h*4+d] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pos(input int x1, input int y1, input int x2, input int y2);
    bus.x_pos = {12'(x2), 12'(x1)};
    bus.y_pos = {12'(y2), 12'(y1)};
  endtask

  task automatic clear_rom();
    for (int i = 0; i < int'(NW); i++) rom[i] = '0;
  endtask

  // Pulses start in the current cycle and returns the cycle count until done is seen.
  task automatic run_scan(output int lat);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  typedef struct {
    int          x1, y1, x2, y2;
    logic [47:0] w0;
    logic [7:0]  exp;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int lat, dones, rnd_x1, rnd_y1, rnd_x2, rnd_y2;
    logic [7:0] got, exp, prev;
    bit stable;

    vecs[0] = '{542, 648, 422, 648, wall(482, 648, 60, 60), 8'h21};
    vecs[1] = '{100, 200, 160, 200, 48'h0, 8'h12};
    vecs[2] = '{0, 300, 2000, 2000, wall(4035, 300, 60, 60), 8'h00};
    vecs[3] = '{2000, 2000, 500, 0, wall(500, 4035, 60, 60), 8'h00};
    vecs[4] = '{300, 60, 2000, 2000, wall(300, 0, 60, 60), 8'h08};
    vecs[5] = '{1000, 1000, 1000, 1060, 48'h0, 8'h84};
    vecs[6] = '{700, 700, 2000, 2000, wall(700, 700, 0, 60), 8'h00};

    bus.start = 1'b0;
    set_pos(0, 0, 0, 0);
    clear_rom();
    repeat (3) @(posedge clk);
    #1;
    check("reset collision", 32'(bus.collision), 0);
    check("reset busy", 32'(bus.busy), 0);
    check("reset done", 32'(bus.done), 0);
    check("reset wall_addr", 32'(bus.wall_addr), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      clear_rom();
      rom[0] = vecs[i].w0;
      set_pos(vecs[i].x1, vecs[i].y1, vecs[i].x2, vecs[i].y2);
      run_scan(lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(LAT));
      check($sformatf("vec%0d collision", i), 32'(bus.collision), 32'(vecs[i].exp));
      check($sformatf("vec%0d busy at done", i), 32'(bus.busy), 0);
      tick();
      check($sformatf("vec%0d done width", i), 32'(bus.done), 0);
    end

    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < int'(NW); i++) begin
        if ($urandom_range(0, 3) == 0) rom[i] = '0;
        else if ($urandom_range(0, 3) == 0)
          rom[i] = {12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom)};
        else
          rom[i] = wall($urandom_range(0, 400), $urandom_range(0, 400),
                        $urandom_range(0, 80), $urandom_range(0, 80));
      end
      if ($urandom_range(0, 3) == 0) begin
        rnd_x1 = $urandom_range(0, 4095);
        rnd_y1 = $urandom_range(0, 4095);
      end else begin
        rnd_x1 = $urandom_range(0, 400);
        rnd_y1 = $urandom_range(0, 400);
      end
      rnd_x2 = $urandom_range(0, 400);
      rnd_y2 = $urandom_range(0, 400);
      set_pos(rnd_x1, rnd_y1, rnd_x2, rnd_y2);
      exp = model(rnd_x1, rnd_y1, rnd_x2, rnd_y2);
      run_scan(lat);
      check($sformatf("rand%0d latency", n), 32'(lat), 32'(LAT));
      check($sformatf("rand%0d collision", n), 32'(bus.collision), 32'(exp));
      tick();
    end

    // Inputs change and start is re-pulsed mid-scan; the snapshot must win.
    clear_rom();
    set_pos(100, 200, 160, 200);
    exp = model(100, 200, 160, 200);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    dones = 0;
    got = '0;
    for (int c = 1; c < 80; c++) begin
      if (bus.done) begin
        dones++;
        got = bus.collision;
      end
      if (c % 4 == 2 && c < 30) begin
        bus.start = 1'b1;
        bus.x_pos = {12'd3000, 12'd1000 + 12'(c)};
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
    check("snapshot done count", 32'(dones), 1);
    check("snapshot collision", 32'(got), 32'(exp));

    // Back-to-back: second start lands in the done cycle.
    clear_rom();
    rom[0] = wall(482, 648, 60, 60);
    set_pos(542, 648, 422, 648);
    run_scan(lat);
    check("b2b first latency", 32'(lat), 32'(LAT));
    check("b2b first collision", 32'(bus.collision), 32'h21);
    prev = bus.collision;
    set_pos(100, 200, 160, 200);
    exp = model(100, 200, 160, 200);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 1;
    stable = 1'b1;
    while (!bus.done && lat < 100) begin
      if (bus.collision !== prev) stable = 1'b0;
      tick();
      lat++;
    end
    check("b2b second latency", 32'(lat), 32'(LAT));
    check("b2b collision stable", 32'(stable), 1);
    check("b2b second collision", 32'(bus.collision), 32'(exp));
    tick();

    // Reset while idle with a non-zero result held.
    rst = 1'b1;
    #1;
    check("idle rst collision", 32'(bus.collision), 0);
    check("idle rst busy", 32'(bus.busy), 0);
    check("idle rst done", 32'(bus.done), 0);
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.done) dones++;
    end
    check("idle rst no done", 32'(dones), 0);

    // Reset in the middle of a scan.
    clear_rom();
    rom[0] = wall(482, 648, 60, 60);
    set_pos(542, 648, 422, 648);
    run_scan(lat);
    check("pre-rst collision", 32'(bus.collision), 32'h21);
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    check("mid-scan busy before rst", 32'(bus.busy), 1);
    rst = 1'b1;
    #1;
    check("scan rst collision", 32'(bus.collision), 0);
    check("scan rst busy", 32'(bus.busy), 0);
    check("scan rst done", 32'(bus.done), 0);
    check("scan rst wall_addr", 32'(bus.wall_addr), 0);
    #1;
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (bus.done) dones++;
    end
    check("scan rst no done", 32'(dones), 0);
    check("scan rst busy after", 32'(bus.busy), 0);

    run_scan(lat);
    check("post-rst latency", 32'(lat), 32'(LAT));
    check("post-rst collision", 32'(bus.collision), 32'h21);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
